pe_conv1d_sched: RTL and testbench

Sequencer that runs one 1-D convolution row on a single MAC processing element.
- Loads K filter taps, then streams image pixels into a K-deep sliding window.
- Per output position, issues K MAC operations to the PE, chaining partial sums through the PE's psum path.
- Returns one 32-bit result per output position over a valid/ready channel.
- Sits between the row buffers / GLB interface and a PE; later scaled to PE arrays.

---
 rtl/pe_pkg.sv | 13 +
 rtl/conv_window.sv | 31 +++
 rtl/pe_conv1d_sched.sv | 177 +++++++++++++++++
 tb/tb_pe_conv1d_sched.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and default sizing for the 1-D convolution scheduler and its window.
package pe_pkg;
   localparam int DEF_KMAX   = 8;
   localparam int DEF_WMAX   = 1024;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_PSUM_W = 32;
   localparam int DEF_PE_LAT = 2;

   typedef enum logic [2:0] {IDLE, LOAD_W, FILL, MAC, WAIT, EMIT, DONE} sched_state_e;

   typedef logic [DEF_DATA_W-1:0] data_t;
   typedef logic [DEF_PSUM_W-1:0] psum_t;
endpackage

// File: rtl/conv_window.sv
// K-deep sliding pixel window: newest pixel enters at index k-1, index 0 holds the oldest.
module conv_window #(
   parameter int KMAX   = 8,
   parameter int DATA_W = 16,
   parameter int KW     = $clog2(KMAX+1),
   parameter int IW     = $clog2(KMAX)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              shift_en,
   input  logic [KW-1:0]     k,
   input  logic [DATA_W-1:0] din,
   input  logic [IW-1:0]     rd_idx,
   output logic [DATA_W-1:0] dout
);
   logic [DATA_W-1:0] win [KMAX];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < KMAX; i++) win[i] <= '0;
      end else if (shift_en) begin
         for (int i = 0; i < KMAX-1; i++) begin
            if (i < int'(k) - 1)       win[i] <= win[i+1];
            else if (i == int'(k) - 1) win[i] <= din;
         end
         if (int'(k) == KMAX) win[KMAX-1] <= din;
      end
   end

   assign dout = win[rd_idx];
endmodule

// File: rtl/pe_conv1d_sched.sv
// Sequencer running one 1-D convolution row on a single MAC PE, chaining partial sums through it.
//
// state  | meaning
// IDLE   | waiting for cfg_start; bad configs pulse cfg_err
// LOAD_W | accepting K filter taps
// FILL   | shifting pixels into the window until 'need' reaches 0
// MAC    | one MAC issue to the PE for the current tap
// WAIT   | down-counting PE latency, then capturing the PE result
// EMIT   | presenting one result on the output channel
// DONE   | one-cycle completion pulse
module pe_conv1d_sched
   import pe_pkg::*;
#(
   parameter int KMAX   = DEF_KMAX,
   parameter int WMAX   = DEF_WMAX,
   parameter int DATA_W = DEF_DATA_W,
   parameter int PSUM_W = DEF_PSUM_W,
   parameter int PE_LAT = DEF_PE_LAT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cfg_start,
   input  logic [$clog2(KMAX+1)-1:0]  cfg_k,
   input  logic [$clog2(WMAX+1)-1:0]  cfg_w,
   output logic                       cfg_err,
   input  logic                       wt_valid,
   output logic                       wt_ready,
   input  logic [DATA_W-1:0]          wt_data,
   input  logic                       img_valid,
   output logic                       img_ready,
   input  logic [DATA_W-1:0]          img_data,
   output logic [DATA_W-1:0]          pe_image_val,
   output logic                       pe_image_en,
   output logic [DATA_W-1:0]          pe_weight_val,
   output logic                       pe_weight_en,
   output logic [PSUM_W-1:0]          pe_psum_in,
   input  logic [PSUM_W-1:0]          pe_psum_out,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [PSUM_W-1:0]          out_data,
   output logic                       busy,
   output logic                       done
);
   localparam int KW = $clog2(KMAX+1);
   localparam int WW = $clog2(WMAX+1);
   localparam int TW = $clog2(KMAX);
   localparam int LW = $clog2(PE_LAT+1);
   localparam logic [KW-1:0] K_MAX_V = KW'(KMAX);
   localparam logic [WW-1:0] W_MAX_V = WW'(WMAX);

   sched_state_e state, nxt;

   logic [KW-1:0]     k_q, need;
   logic [WW-1:0]     w_q, ocnt;
   logic [TW-1:0]     tap;
   logic [LW-1:0]     wcnt;
   logic [PSUM_W-1:0] acc;
   logic [DATA_W-1:0] wt_mem [KMAX];
   logic [DATA_W-1:0] win_dout;
   logic              cfg_err_q;
   logic              cfg_ok, wt_fire, img_fire, last_tap, last_out;

   assign cfg_ok   = (cfg_k != '0) && (cfg_k <= K_MAX_V) &&
                     (cfg_w >= WW'(cfg_k)) && (cfg_w <= W_MAX_V);
   assign wt_fire  = wt_valid  && (state == LOAD_W);
   assign img_fire = img_valid && (state == FILL);
   assign last_tap = (KW'(tap) == k_q - KW'(1));
   assign last_out = (ocnt + WW'(1)) == (w_q - WW'(k_q) + WW'(1));

   conv_window #(.KMAX(KMAX), .DATA_W(DATA_W)) u_window (
      .clk      (clk),
      .rst      (rst),
      .shift_en (img_fire),
      .k        (k_q),
      .din      (img_data),
      .rd_idx   (tap),
      .dout     (win_dout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (cfg_start && cfg_ok) nxt = LOAD_W;
         LOAD_W:  if (wt_fire && last_tap) nxt = FILL;
         FILL:    if (img_fire && need == KW'(1)) nxt = MAC;
         MAC:     nxt = WAIT;
         WAIT:    if (wcnt == LW'(1)) nxt = last_tap ? EMIT : MAC;
         EMIT:    if (out_ready) nxt = last_out ? DONE : FILL;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_q       <= '0;
         w_q       <= '0;
         need      <= '0;
         ocnt      <= '0;
         tap       <= '0;
         wcnt      <= '0;
         acc       <= '0;
         cfg_err_q <= 1'b0;
         for (int i = 0; i < KMAX; i++) wt_mem[i] <= '0;
      end else begin
         cfg_err_q <= (state == IDLE) && cfg_start && !cfg_ok;
         case (state)
            IDLE: if (cfg_start) begin
               k_q  <= cfg_k;
               w_q  <= cfg_w;
               tap  <= '0;
               ocnt <= '0;
            end
            LOAD_W: if (wt_fire) begin
               wt_mem[tap] <= wt_data;
               tap         <= tap + 1'b1;
               need        <= k_q;
            end
            FILL: if (img_fire) begin
               need <= need - 1'b1;
               tap  <= '0;
            end
            MAC: wcnt <= LW'(PE_LAT);
            WAIT: begin
               wcnt <= wcnt - 1'b1;
               // The PE result for this tap is valid exactly on the last wait cycle.
               if (wcnt == LW'(1)) begin
                  acc <= pe_psum_out;
                  if (!last_tap) tap <= tap + 1'b1;
               end
            end
            EMIT: if (out_ready) begin
               ocnt <= ocnt + 1'b1;
               need <= KW'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      wt_ready      = 1'b0;
      img_ready     = 1'b0;
      pe_image_en   = 1'b0;
      pe_weight_en  = 1'b0;
      pe_image_val  = '0;
      pe_weight_val = '0;
      pe_psum_in    = '0;
      out_valid     = 1'b0;
      out_data      = '0;
      case (state)
         LOAD_W: wt_ready = 1'b1;
         FILL:   img_ready = 1'b1;
         MAC: begin
            pe_image_en   = 1'b1;
            pe_weight_en  = 1'b1;
            pe_image_val  = win_dout;
            pe_weight_val = wt_mem[tap];
            pe_psum_in    = (tap == '0) ? '0 : acc;
         end
         EMIT: begin
            out_valid = 1'b1;
            out_data  = acc;
         end
         default: ;
      endcase
   end

   assign cfg_err = cfg_err_q;
   assign busy    = (state != IDLE);
   assign done    = (state == DONE);
endmodule

// File: tb/tb_pe_conv1d_sched.sv
// Self-checking bench for pe_conv1d_sched with a behavioural PE and a direct-sum reference model.
module tb_pe_conv1d_sched;
   import pe_pkg::*;

   localparam int KMAX = 8, WMAX = 1024, DW = 16, PW = 32, BUDGET = 4000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          cfg_start, cfg_err;
   logic [3:0]    cfg_k;
   logic [10:0]   cfg_w;
   logic          wt_valid, wt_ready, img_valid, img_ready;
   logic [DW-1:0] wt_data, img_data, pe_image_val, pe_weight_val;
   logic          pe_image_en, pe_weight_en, out_valid, out_ready, busy, done;
   psum_t         pe_psum_in, pe_psum_out, out_data;

   pe_conv1d_sched dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_k(cfg_k), .cfg_w(cfg_w),
      .cfg_err(cfg_err), .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
      .img_valid(img_valid), .img_ready(img_ready), .img_data(img_data),
      .pe_image_val(pe_image_val), .pe_image_en(pe_image_en),
      .pe_weight_val(pe_weight_val), .pe_weight_en(pe_weight_en),
      .pe_psum_in(pe_psum_in), .pe_psum_out(pe_psum_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .done(done)
   );

   // Behavioural PE: result of an issued MAC appears two cycles later.
   psum_t pe_p0, pe_p1;
   always @(posedge clk) begin
      if (pe_image_en) pe_p0 <= pe_psum_in + PW'(pe_image_val) * PW'(pe_weight_val);
      pe_p1 <= pe_p0;
   end
   assign pe_psum_out = pe_p1;

   int unsigned wts [KMAX];
   int unsigned pix [WMAX];
   psum_t got[$];
   psum_t exp_q[$];
   int    n_pass = 0, n_total = 0;
   int    k_cur = 1, timeouts, stall_left, stall_bad;
   psum_t stall_ref;
   bit    abort, gap_mode;
   logic [7:0] snap_ctl;
   logic       snap_data;

   int mac_cnt, mac_bad, done_cnt, mj, mt;
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (pe_image_en) begin
         mj = mac_cnt / k_cur;
         mt = mac_cnt % k_cur;
         if (pe_image_val !== DW'(pix[mj+mt]) || pe_weight_val !== DW'(wts[mt]) ||
             pe_weight_en !== 1'b1 || (mt == 0 && pe_psum_in !== '0))
            mac_bad++;
         mac_cnt++;
      end
   end

   function automatic void build_exp(input int k, input int w);
      exp_q.delete();
      for (int j = 0; j <= w - k; j++) begin
         psum_t s = '0;
         for (int t = 0; t < k; t++) s += PW'(pix[j+t]) * PW'(wts[t]);
         exp_q.push_back(s);
      end
   endfunction

   task automatic load_basic();
      for (int t = 0; t < 3; t++) wts[t] = t + 1;
      for (int i = 0; i < 5; i++) pix[i] = i + 1;
   endtask

   task automatic feed_wt(input int n);
      int i = 0, cyc = 0;
      while (i < n && !abort && cyc < BUDGET) begin
         @(negedge clk); cyc++;
         wt_valid = gap_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         wt_data  = DW'(wts[i]);
         if (wt_valid && wt_ready) i++;
      end
      @(negedge clk); wt_valid = 1'b0;
      if (i < n && !abort) timeouts++;
   endtask

   task automatic feed_img(input int n);
      int i = 0, cyc = 0;
      while (i < n && !abort && cyc < BUDGET) begin
         @(negedge clk); cyc++;
         img_valid = gap_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         img_data  = DW'(pix[i]);
         if (img_valid && img_ready) i++;
      end
      @(negedge clk); img_valid = 1'b0;
      if (i < n && !abort) timeouts++;
   endtask

   task automatic collect(input int n);
      int cyc = 0;
      while (got.size() < n && !abort && cyc < BUDGET) begin
         @(negedge clk); cyc++;
         if (out_valid && got.size() == 0 && stall_left > 0) begin
            out_ready = 1'b0;
            if (stall_left < 10 && out_data !== stall_ref) stall_bad++;
            if (img_ready || pe_image_en || pe_weight_en) stall_bad++;
            stall_ref = out_data;
            stall_left--;
         end else begin
            out_ready = gap_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) got.push_back(out_data);
         end
      end
      @(negedge clk); out_ready = 1'b0;
      if (got.size() < n && !abort) timeouts++;
   endtask

   task automatic watch_rst(input int target);
      int seen = 0, cyc = 0;
      if (target < 0) return;
      while (cyc < BUDGET) begin
         @(negedge clk); cyc++;
         if (pe_image_en) begin
            if (seen == target) break;
            seen++;
         end
      end
      if (cyc >= BUDGET) timeouts++;
      rst = 1'b1;
      #1;
      snap_ctl  = {cfg_err, wt_ready, img_ready, pe_image_en, pe_weight_en, out_valid, busy, done};
      snap_data = |{pe_image_val, pe_weight_val, pe_psum_in, out_data};
      abort = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_conv(input int k, input int w, input int rst_at);
      k_cur = k; got.delete();
      mac_cnt = 0; mac_bad = 0; done_cnt = 0; timeouts = 0; stall_bad = 0;
      @(negedge clk); cfg_k = 4'(k); cfg_w = 11'(w); cfg_start = 1'b1;
      @(negedge clk); cfg_start = 1'b0;
      fork
         feed_wt(k);
         feed_img(w);
         collect(w - k + 1);
         watch_rst(rst_at);
      join
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_total++;
      if ({cfg_err, wt_ready, img_ready, pe_image_en, pe_weight_en, out_valid, busy, done} !== 8'h00) begin
         $display("FAIL reset_ctl got=%b want=00000000",
                  {cfg_err, wt_ready, img_ready, pe_image_en, pe_weight_en, out_valid, busy, done});
      end else n_pass++;
      n_total++;
      if ((|{pe_image_val, pe_weight_val, pe_psum_in, out_data}) !== 1'b0)
         $display("FAIL reset_data got nonzero data outputs want=0");
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int want [3] = '{14, 20, 26};
      load_basic(); gap_mode = 0; stall_left = 0;
      run_conv(3, 5, -1);
      n_total++; if (timeouts !== 0) $display("FAIL basic_timeout got=%0d want=0", timeouts); else n_pass++;
      n_total++; if (got.size() !== 3) $display("FAIL basic_count got=%0d want=3", got.size()); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         n_total++;
         if (got[i] !== PW'(want[i])) $display("FAIL basic_out%0d got=%0d want=%0d", i, got[i], want[i]);
         else n_pass++;
      end
      n_total++; if (mac_cnt !== 9) $display("FAIL basic_macs got=%0d want=9", mac_cnt); else n_pass++;
      n_total++; if (mac_bad !== 0) $display("FAIL basic_mac_ops got=%0d bad want=0", mac_bad); else n_pass++;
      n_total++; if (done_cnt !== 1) $display("FAIL basic_done got=%0d want=1", done_cnt); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL basic_idle busy=%b want=0", busy); else n_pass++;
   endtask

   task automatic test_k1();
      int want [4] = '{14, 0, 35, 458745};
      wts[0] = 7; pix[0] = 2; pix[1] = 0; pix[2] = 5; pix[3] = 65535;
      gap_mode = 0; stall_left = 0;
      run_conv(1, 4, -1);
      n_total++; if (got.size() !== 4 || timeouts !== 0)
         $display("FAIL k1_count got=%0d timeouts=%0d want=4/0", got.size(), timeouts); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_total++;
         if (got[i] !== PW'(want[i])) $display("FAIL k1_out%0d got=%0d want=%0d", i, got[i], want[i]);
         else n_pass++;
      end
      n_total++; if (mac_cnt !== 4 || mac_bad !== 0)
         $display("FAIL k1_macs got=%0d bad=%0d want=4/0", mac_cnt, mac_bad); else n_pass++;
   endtask

   task automatic test_backpressure();
      int want [3] = '{14, 20, 26};
      load_basic(); gap_mode = 0; stall_left = 10;
      run_conv(3, 5, -1);
      n_total++; if (stall_left !== 0) $display("FAIL bp_stall_cycles left=%0d want=0", stall_left); else n_pass++;
      n_total++; if (stall_bad !== 0) $display("FAIL bp_stable got=%0d bad want=0", stall_bad); else n_pass++;
      n_total++; if (stall_ref !== 32'd14) $display("FAIL bp_held got=%0d want=14", stall_ref); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         n_total++;
         if (got[i] !== PW'(want[i])) $display("FAIL bp_out%0d got=%0d want=%0d", i, got[i], want[i]);
         else n_pass++;
      end
      n_total++; if (done_cnt !== 1) $display("FAIL bp_done got=%0d want=1", done_cnt); else n_pass++;
   endtask

   task automatic test_gaps();
      load_basic(); build_exp(3, 5); gap_mode = 1; stall_left = 0;
      run_conv(3, 5, -1);
      gap_mode = 0;
      n_total++; if (got.size() !== 3 || timeouts !== 0)
         $display("FAIL gaps_count got=%0d timeouts=%0d want=3/0", got.size(), timeouts); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         n_total++;
         if (got[i] !== exp_q[i]) $display("FAIL gaps_out%0d got=%0d want=%0d", i, got[i], exp_q[i]);
         else n_pass++;
      end
      n_total++; if (mac_bad !== 0 || mac_cnt !== 9)
         $display("FAIL gaps_macs got=%0d bad=%0d want=9/0", mac_cnt, mac_bad); else n_pass++;
   endtask

   task automatic test_bad_cfg();
      int ks [3] = '{0, 4, KMAX + 1};
      int ws [3] = '{5, 3, 20};
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); cfg_k = 4'(ks[c]); cfg_w = 11'(ws[c]); cfg_start = 1'b1;
         @(negedge clk); cfg_start = 1'b0;
         n_total++;
         if (cfg_err !== 1'b1 || busy !== 1'b0)
            $display("FAIL badcfg%0d_err got err=%b busy=%b want err=1 busy=0", c, cfg_err, busy);
         else n_pass++;
         @(negedge clk);
         n_total++;
         if (cfg_err !== 1'b0 || busy !== 1'b0 || wt_ready !== 1'b0 || img_ready !== 1'b0)
            $display("FAIL badcfg%0d_after got err=%b busy=%b wr=%b ir=%b want all 0",
                     c, cfg_err, busy, wt_ready, img_ready);
         else n_pass++;
      end
   endtask

   task automatic test_reset_midrun();
      int want [3] = '{14, 20, 26};
      load_basic(); gap_mode = 0; stall_left = 0; abort = 0;
      run_conv(3, 5, 4);
      n_total++; if (timeouts !== 0) $display("FAIL rstmid_reach timeouts=%0d want=0", timeouts); else n_pass++;
      n_total++; if (snap_ctl !== 8'h00) $display("FAIL rstmid_ctl got=%b want=00000000", snap_ctl); else n_pass++;
      n_total++; if (snap_data !== 1'b0) $display("FAIL rstmid_data got nonzero want=0"); else n_pass++;
      n_total++; if (got.size() !== 1 || got[0] !== 32'd14)
         $display("FAIL rstmid_partial got=%0d results want=1 (14)", got.size()); else n_pass++;
      n_total++; if (busy !== 1'b0 || out_valid !== 1'b0)
         $display("FAIL rstmid_idle busy=%b out_valid=%b want 0/0", busy, out_valid); else n_pass++;
      abort = 0;
      run_conv(3, 5, -1);
      for (int i = 0; i < 3; i++) begin
         n_total++;
         if (got[i] !== PW'(want[i])) $display("FAIL rstmid_rerun%0d got=%0d want=%0d", i, got[i], want[i]);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 5; it++) begin
         int k, w;
         k = $urandom_range(1, KMAX);
         w = k + $urandom_range(0, 10);
         for (int t = 0; t < k; t++) wts[t] = $urandom_range(0, 65535);
         for (int i = 0; i < w; i++) pix[i] = $urandom_range(0, 65535);
         gap_mode = 1'($urandom_range(0, 1)); stall_left = 0;
         build_exp(k, w);
         run_conv(k, w, -1);
         n_total++;
         if (got.size() !== exp_q.size() || timeouts !== 0)
            $display("FAIL rand%0d_count k=%0d w=%0d got=%0d want=%0d", it, k, w, got.size(), exp_q.size());
         else n_pass++;
         for (int j = 0; j < exp_q.size(); j++) begin
            n_total++;
            if (got[j] !== exp_q[j]) $display("FAIL rand%0d_out%0d got=%0d want=%0d", it, j, got[j], exp_q[j]);
            else n_pass++;
         end
         n_total++;
         if (mac_cnt !== k * exp_q.size() || mac_bad !== 0 || done_cnt !== 1)
            $display("FAIL rand%0d_seq macs=%0d bad=%0d done=%0d want %0d/0/1",
                     it, mac_cnt, mac_bad, done_cnt, k * exp_q.size());
         else n_pass++;
      end
      gap_mode = 0;
   endtask

   initial begin
      rst = 1'b1; cfg_start = 1'b0; cfg_k = '0; cfg_w = '0;
      wt_valid = 1'b0; wt_data = '0; img_valid = 1'b0; img_data = '0; out_ready = 1'b0;
      abort = 0; gap_mode = 0; stall_left = 0; stall_ref = '0;
      snap_ctl = '0; snap_data = 1'b0;
      mac_cnt = 0; mac_bad = 0; done_cnt = 0; timeouts = 0; stall_bad = 0;
      test_reset();
      test_basic();
      test_k1();
      test_backpressure();
      test_gaps();
      test_bad_cfg();
      test_reset_midrun();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
